// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared state encoding and sizing for the boot loader.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_RUN,
        S_ERROR,
        S_CHK
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEF_ADDR_W     = 6;

    // Legal load length tops out at the full instruction memory depth.
    function automatic int max_words_for(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// imem_boot_loader_byte_word_assembler: packs consecutive bytes little-endian into a 32-bit word.
module imem_boot_loader_byte_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;

    always_comb begin
        cnt_d  = clr_i ? '0 : byte_en_i ? cnt_q + 1'b1 : cnt_q;
        word_d = clr_i ? '0 : word_q;
        if (byte_en_i && !clr_i)
            word_d[8*cnt_q +: 8] = byte_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = byte_en_i && cnt_q == CNT_W'(BYTES_PER_WORD - 1);

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams bytes into instruction memory and holds the core in reset until loaded.
// Define IMEM_BOOT_CHECKSUM_EN to require a trailing XOR check byte before releasing the core.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_WORDS = max_words_for(ADDR_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MAX_WORDS);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                done_q;
    logic                clr, byte_en, word_full, legal, last;
    logic [31:0]         word;

`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_t S_POST = S_CHK;
    logic [7:0] xor_q, xor_d;
`else
    localparam state_t S_POST = S_RUN;
`endif

    assign legal   = len_words != '0 && len_words <= MAX_LEN;
    assign last    = {1'b0, idx_q} == len_q - 1'b1;
    assign byte_en = rx_valid && state_q == S_RECV;

    imem_boot_loader_byte_word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr),
        .byte_en_i   (byte_en),
        .byte_i      (rx_data),
        .word_o      (word),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: if (start) begin
                state_d = legal ? S_RECV : S_ERROR;
                len_d   = legal ? len_words : len_q;
                idx_d   = '0;
                clr     = legal;
            end
            S_RECV: if (word_full) state_d = S_WRITE;
            S_WRITE: begin
                state_d = last ? S_POST : S_RECV;
                idx_d   = last ? idx_q : idx_q + 1'b1;
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CHK: if (rx_valid) state_d = rx_data == xor_q ? S_RUN : S_ERROR;
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef IMEM_BOOT_CHECKSUM_EN
        xor_d = clr ? '0 : byte_en ? xor_q ^ rx_data : xor_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            done_q  <= state_d == S_RUN && state_q != S_RUN;
`ifdef IMEM_BOOT_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign rx_ready   = state_q == S_RECV || state_q == S_CHK;
    assign imem_we    = state_q == S_WRITE;
    assign imem_addr  = {{(30 - ADDR_W){1'b0}}, idx_q, 2'b00};
    assign imem_wdata = word;
    assign cpu_rst    = state_q != S_RUN;
    assign busy       = state_q == S_RECV || state_q == S_WRITE || state_q == S_CHK;
    assign done       = done_q;
    assign err        = state_q == S_ERROR;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed checks of load, backpressure, illegal length and mid-load reset.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  len_words = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, imem_we, cpu_rst, busy, done, err;
    logic [31:0] imem_addr, imem_wdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] wa [8];
    logic [31:0] wd [8];
    int wn = 0;
    int done_cnt = 0;
    int done_bad = 0;

    logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    imem_boot_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_words  (len_words),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            if (wn < 8) begin
                wa[wn] = imem_addr;
                wd[wn] = imem_wdata;
            end
            wn++;
        end
        if (done) begin
            done_cnt++;
            if (cpu_rst) done_bad++;
        end
    end

    task automatic pulse_start(input logic [6:0] len);
        start = 1'b1;
        len_words = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bit acc = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_byte: byte %02h not accepted within %0d cycles", b, n);
        end
    endtask

    task automatic wait_run(input string name);
        int n = 0;
        while (cpu_rst && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (cpu_rst !== 1'b0) begin
            fails++;
            $display("FAIL %s_release: cpu_rst=%b after %0d cycles, expected 0", name, cpu_rst, n);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({cpu_rst, rx_ready, imem_we, busy, done, err} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_outputs: cpu_rst,rx_ready,we,busy,done,err=%b expected 100000",
                     {cpu_rst, rx_ready, imem_we, busy, done, err});
        end
        tests++;
        if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus: addr=%h wdata=%h expected 0/0", imem_addr, imem_wdata);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if ({cpu_rst, rx_ready, busy, err} !== 4'b1000) begin
            fails++;
            $display("FAIL idle_hold: cpu_rst,rx_ready,busy,err=%b expected 1000",
                     {cpu_rst, rx_ready, busy, err});
        end
    endtask

    task automatic check_two_words(input string name);
        tests++;
        if (wn !== 2) begin
            fails++;
            $display("FAIL %s_count: %0d writes, expected 2", name, wn);
        end
        tests++;
        if (wa[0] !== 32'h0 || wd[0] !== 32'h00500013) begin
            fails++;
            $display("FAIL %s_word0: addr=%h data=%h expected 00000000/00500013", name, wa[0], wd[0]);
        end
        tests++;
        if (wa[1] !== 32'h4 || wd[1] !== 32'h00100093) begin
            fails++;
            $display("FAIL %s_word1: addr=%h data=%h expected 00000004/00100093", name, wa[1], wd[1]);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (done_cnt !== 1 || done_bad !== 0) begin
            fails++;
            $display("FAIL %s_done: pulses=%0d with_cpu_rst=%0d expected 1/0", name, done_cnt, done_bad);
        end
        tests++;
        if ({cpu_rst, busy, done, err} !== 4'b0000) begin
            fails++;
            $display("FAIL %s_run: cpu_rst,busy,done,err=%b expected 0000", name, {cpu_rst, busy, done, err});
        end
    endtask

    task automatic test_load_two_words;
        wn = 0; done_cnt = 0; done_bad = 0;
        pulse_start(7'd2);
        tests++;
        if ({rx_ready, busy, cpu_rst} !== 3'b111) begin
            fails++;
            $display("FAIL load_recv_entry: rx_ready,busy,cpu_rst=%b expected 111", {rx_ready, busy, cpu_rst});
        end
        for (int i = 0; i < 8; i++) send_byte(prog[i]);
        rx_valid = 1'b0;
        wait_run("load");
        check_two_words("load");
    endtask

    task automatic test_backpressure;
        wn = 0; done_cnt = 0; done_bad = 0;
        pulse_start(7'd2);
        tests++;
        if (cpu_rst !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL bp_restart: cpu_rst=%b busy=%b expected 1/1", cpu_rst, busy);
        end
        for (int i = 0; i < 8; i++) begin
            send_byte(prog[i]);
            if (i == 3) begin
                tests++;
                if ({imem_we, rx_ready} !== 2'b10 || imem_addr !== 32'h0) begin
                    fails++;
                    $display("FAIL bp_write_cycle: we,rx_ready=%b addr=%h expected 10/0",
                             {imem_we, rx_ready}, imem_addr);
                end
            end else if (i != 7) begin
                rx_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b0;
        wait_run("bp");
        check_two_words("bp");
    endtask

    task automatic test_illegal_len;
        wn = 0; done_cnt = 0; done_bad = 0;
        pulse_start(7'd0);
        tests++;
        if ({err, cpu_rst, busy} !== 3'b110) begin
            fails++;
            $display("FAIL illegal_len0: err,cpu_rst,busy=%b expected 110", {err, cpu_rst, busy});
        end
        pulse_start(7'd65);
        rx_valid = 1'b1;
        rx_data = 8'hee;
        repeat (2) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        tests++;
        if ({err, cpu_rst, rx_ready} !== 3'b110 || wn !== 0) begin
            fails++;
            $display("FAIL illegal_len65: err,cpu_rst,rx_ready=%b writes=%0d expected 110/0",
                     {err, cpu_rst, rx_ready}, wn);
        end
        pulse_start(7'd1);
        tests++;
        if (err !== 1'b0 || rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL illegal_recover: err=%b rx_ready=%b expected 0/1", err, rx_ready);
        end
        send_byte(8'hb7); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        rx_valid = 1'b0;
        wait_run("len1");
        tests++;
        if (wn !== 1 || wa[0] !== 32'h0 || wd[0] !== 32'h000000b7 || done_cnt !== 1) begin
            fails++;
            $display("FAIL len1_load: writes=%0d addr=%h data=%h done=%0d expected 1/0/000000b7/1",
                     wn, wa[0], wd[0], done_cnt);
        end
    endtask

    task automatic test_reset_mid_load;
        wn = 0; done_cnt = 0;
        pulse_start(7'd2);
        for (int i = 0; i < 6; i++) send_byte(prog[i]);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({cpu_rst, rx_ready, imem_we, busy, done, err} !== 6'b100000 ||
            imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL midrst_outputs: flags=%b addr=%h wdata=%h expected 100000/0/0",
                     {cpu_rst, rx_ready, imem_we, busy, done, err}, imem_addr, imem_wdata);
        end
        tests++;
        if (wn !== 1 || wa[0] !== 32'h0 || wd[0] !== 32'h00500013) begin
            fails++;
            $display("FAIL midrst_writes: writes=%0d addr=%h data=%h expected 1/0/00500013", wn, wa[0], wd[0]);
        end
        rx_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({cpu_rst, busy, done_cnt == 0} !== 3'b101) begin
            fails++;
            $display("FAIL midrst_idle: cpu_rst=%b busy=%b done_pulses=%0d expected 1/0/0", cpu_rst, busy, done_cnt);
        end
    endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
    task automatic test_checksum;
        wn = 0; done_cnt = 0; done_bad = 0;
        pulse_start(7'd1);
        for (int i = 0; i < 4; i++) send_byte(prog[i]);
        send_byte(8'h43);
        rx_valid = 1'b0;
        wait_run("chk_ok");
        tests++;
        if (done_cnt !== 1 || err !== 1'b0 || wd[0] !== 32'h00500013) begin
            fails++;
            $display("FAIL chk_ok: done=%0d err=%b data=%h expected 1/0/00500013", done_cnt, err, wd[0]);
        end
        pulse_start(7'd1);
        for (int i = 0; i < 4; i++) send_byte(prog[i]);
        send_byte(8'h00);
        rx_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({err, cpu_rst, busy} !== 3'b110 || done_cnt !== 1) begin
            fails++;
            $display("FAIL chk_bad: err,cpu_rst,busy=%b done=%0d expected 110/1", {err, cpu_rst, busy}, done_cnt);
        end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_two_words();
        test_backpressure();
        test_illegal_len();
        test_reset_mid_load();
`ifdef IMEM_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
